// File: rtl/ofd2_out_sched_if.sv
// ofd2_out_sched_if: requester-side bus and ofd2 D0/D1 outputs of the round-robin scheduler
interface ofd2_out_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] dat;
  logic [NREQ-1:0]   ack;
  logic              d0;
  logic              d1;
  logic [IDW-1:0]    gnt_id;
  logic              busy;
  modport master (output req, dat, input ack, d0, d1, gnt_id, busy);
  modport slave  (input req, dat, output ack, d0, d1, gnt_id, busy);
endinterface

// File: rtl/ofd2_out_sched.sv
// ofd2_out_sched: round-robin share of one ofd2 D0/D1 pair, HOLD cycles per word then GAP idle cycles
// Option: OFD2_SCHED_PARK_EN keeps the last word on D0/D1 through GAP and IDLE.
module ofd2_out_sched #(
  parameter int   NREQ  = 4,
  parameter int   IDW   = 2,
  parameter int   HOLD  = 2,
  parameter int   GAP   = 1,
  parameter logic IDLE0 = 1'b0,
  parameter logic IDLE1 = 1'b0
) (
  input  logic ck_i,
  input  logic rst_n_i,
  ofd2_out_sched_if.slave bus
);
  localparam int CW    = $clog2(((HOLD > GAP) ? HOLD : GAP) + 1);
  localparam int GAPM1 = (GAP > 0) ? GAP - 1 : 0;
`ifdef OFD2_SCHED_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IDW-1:0]      ptr_q, ptr_d, gnt_q, gnt_d, sel;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                d0_q, d0_d, d1_q, d1_d, found, arb;
  logic [IDW:0]        idx;
  logic [NREQ-1:0][1:0] word;
  assign word = bus.dat;
  // first requester at or after ptr, wrapping explicitly so any NREQ works
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      idx = (idx >= (IDW+1)'(NREQ)) ? idx - (IDW+1)'(NREQ) : idx;
      if (!found && bus.req[idx[IDW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    d0_d    = d0_q;
    d1_d    = d1_q;
    arb     = 1'b0;
    case (state_q)
      S_DRIVE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (GAP == 0) arb = 1'b1;
        else begin
          d0_d    = PARK ? d0_q : IDLE0;
          d1_d    = PARK ? d1_q : IDLE1;
          cnt_d   = CW'(GAPM1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else arb = 1'b1;
      end
      default: arb = 1'b1;
    endcase
    if (arb) begin
      if (found) begin
        d0_d       = word[sel][0];
        d1_d       = word[sel][1];
        ack_d[sel] = 1'b1;
        gnt_d      = sel;
        ptr_d      = (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
        cnt_d      = CW'(HOLD-1);
        state_d    = S_DRIVE;
      end else begin
        d0_d    = PARK ? d0_q : IDLE0;
        d1_d    = PARK ? d1_q : IDLE1;
        state_d = S_IDLE;
      end
    end
  end
  always_ff @(posedge ck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      d0_q    <= IDLE0;
      d1_q    <= IDLE1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end
  assign bus.ack    = ack_q;
  assign bus.d0     = d0_q;
  assign bus.d1     = d1_q;
  assign bus.gnt_id = gnt_q;
  assign bus.busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_ofd2_out_sched.sv
// tb_ofd2_out_sched: directed checks of the scheduler, GAP=1 instance plus a GAP=0 instance
module tb_ofd2_out_sched;
`ifdef OFD2_SCHED_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  ofd2_out_sched_if #(.NREQ(4), .IDW(2)) b1 ();
  ofd2_out_sched_if #(.NREQ(4), .IDW(2)) b2 ();
  ofd2_out_sched #(.NREQ(4), .IDW(2), .HOLD(2), .GAP(1)) dut1 (.ck_i(clk), .rst_n_i(rst_n), .bus(b1));
  ofd2_out_sched #(.NREQ(4), .IDW(2), .HOLD(2), .GAP(0)) dut2 (.ck_i(clk), .rst_n_i(rst_n), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    int n, last, w;
    b1.req = 4'hF; b1.dat = 8'hFF;
    b2.req = 4'h0; b2.dat = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_d", {b1.d1, b1.d0}, 2'b00);
      chk("rst_ack", b1.ack, 4'h0);
      chk("rst_busy", b1.busy, 1'b0);
      chk("rst_gnt", b1.gnt_id, 2'd0);
    end
    b1.req = 4'h0; rst_n = 1'b1;
    step();
    chk("idle_busy", b1.busy, 1'b0);
    b1.req = 4'b0100; b1.dat = 8'b00_10_00_00;
    step();
    chk("t2_ack", b1.ack, 4'b0100);
    chk("t2_d_a", {b1.d1, b1.d0}, 2'b10);
    chk("t2_gnt", b1.gnt_id, 2'd2);
    b1.req = 4'h0;
    step();
    chk("t2_ack1", b1.ack, 4'h0);
    chk("t2_d_b", {b1.d1, b1.d0}, 2'b10);
    step();
    chk("t2_gap_d", {b1.d1, b1.d0}, PARK ? 2'b10 : 2'b00);
    chk("t2_gap_busy", b1.busy, 1'b1);
    step();
    chk("t2_idle_busy", b1.busy, 1'b0);
    chk("t2_idle_d", {b1.d1, b1.d0}, PARK ? 2'b10 : 2'b00);
    chk("t2_gnt_hold", b1.gnt_id, 2'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; b1.req = 4'hF; b1.dat = 8'b11_10_01_00;
    n = 0; last = 0;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      do begin
        step(); n++; w++;
      end while (b1.ack == 4'h0 && w < 8);
      chk("t3_ack", b1.ack, 4'b1 << (g % 4));
      chk("t3_gnt", b1.gnt_id, g % 4);
      chk("t3_d", {b1.d1, b1.d0}, g % 4);
      if (g > 0) chk("t3_space", n - last, 3);
      last = n;
    end
    b1.req = 4'h0;
    b2.req = 4'b0011; b2.dat = 8'b0000_10_01;
    step();
    chk("t4_ack0", b2.ack, 4'b0001);
    chk("t4_d0", {b2.d1, b2.d0}, 2'b01);
    chk("t4_gnt0", b2.gnt_id, 2'd0);
    b2.req = 4'b0010;
    step();
    chk("t4_d0b", {b2.d1, b2.d0}, 2'b01);
    chk("t4_ack_gap", b2.ack, 4'h0);
    step();
    chk("t4_ack1", b2.ack, 4'b0010);
    chk("t4_d1", {b2.d1, b2.d0}, 2'b10);
    chk("t4_gnt1", b2.gnt_id, 2'd1);
    b2.req = 4'h0;
    step();
    chk("t4_d1b", {b2.d1, b2.d0}, 2'b10);
    step();
    chk("t4_idle_d", {b2.d1, b2.d0}, PARK ? 2'b10 : 2'b00);
    chk("t4_idle_busy", b2.busy, 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; b1.req = 4'b1000; b1.dat = 8'b11_00_00_00;
    step();
    chk("t5_ack", b1.ack, 4'b1000);
    chk("t5_d", {b1.d1, b1.d0}, 2'b11);
    step();
    chk("t5_drive2", {b1.d1, b1.d0}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("t5_abort_d", {b1.d1, b1.d0}, 2'b00);
    chk("t5_abort_busy", b1.busy, 1'b0);
    chk("t5_abort_gnt", b1.gnt_id, 2'd0);
    chk("t5_abort_ack", b1.ack, 4'h0);
    step();
    chk("t5_rst_d", {b1.d1, b1.d0}, 2'b00);
    rst_n = 1'b1;
    step();
    chk("t5_regrant", b1.ack, 4'b1000);
    chk("t5_regnt", b1.gnt_id, 2'd3);
    chk("t5_red", {b1.d1, b1.d0}, 2'b11);
    b1.req = 4'h0;
    step();
    chk("t6_drive", {b1.d1, b1.d0}, 2'b11);
    step();
    chk("t6_gap", {b1.d1, b1.d0}, PARK ? 2'b11 : 2'b00);
    step();
    chk("t6_idle", {b1.d1, b1.d0}, PARK ? 2'b11 : 2'b00);
    chk("t6_busy", b1.busy, 1'b0);
    step();
    chk("t6_idle2", {b1.d1, b1.d0}, PARK ? 2'b11 : 2'b00);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
